// File: rtl/gemm_mac_unit.sv
// Serial signed dot-product engine: accumulates one element product per cycle over
// S2P_SIZE**2-element blocks and emits the sum after i_blocks blocks.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef S2P_SIZE
`define S2P_SIZE 3
`endif

module gemm_mac_unit #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int S2P_SIZE   = `S2P_SIZE,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                                        clk,
   input  logic                                        rstn,
   input  logic                                        i_flag_buffer,
   input  logic [S2P_SIZE*S2P_SIZE*DATA_WIDTH-1:0]     i_matrix_tensor,
   input  logic [S2P_SIZE*S2P_SIZE*DATA_WIDTH-1:0]     i_matrix_weight,
   input  logic [7:0]                                  i_blocks,
   output logic [ACC_WIDTH-1:0]                        o_result,
   output logic                                        o_result_valid,
   output logic                                        o_busy,
   output logic                                        o_drop
);

   localparam int N     = S2P_SIZE * S2P_SIZE;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic {IDLE, MAC} state_t;

   state_t                        state, state_next;
   logic signed [DATA_WIDTH-1:0]  tensor_q [N];
   logic signed [DATA_WIDTH-1:0]  weight_q [N];
   logic [IDX_W-1:0]              idx;
   logic [7:0]                    blk_cnt;
   logic [7:0]                    blk_total;
   logic signed [ACC_WIDTH-1:0]   acc;
   logic signed [ACC_WIDTH-1:0]   acc_next;
   logic signed [ACC_WIDTH-1:0]   prod_ext;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic                          last_elem;
   logic                          final_blk;
   logic                          accept;
   logic                          group_start;
   logic                          drop;

   // The single multiplier is shared across elements by muxing on idx.
   assign prod      = tensor_q[idx] * weight_q[idx];
   assign prod_ext  = ACC_WIDTH'(prod);
   assign acc_next  = acc + prod_ext;
   assign final_blk = (blk_cnt == blk_total - 8'd1);
   assign o_busy    = (state == MAC);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next  = state;
      accept      = 1'b0;
      drop        = 1'b0;
      last_elem   = 1'b0;
      group_start = 1'b0;
      case (state)
         IDLE: begin
            accept      = i_flag_buffer;
            group_start = (blk_cnt == 8'd0);
            if (accept) state_next = MAC;
         end
         MAC: begin
            last_elem   = (idx == LAST_IDX);
            accept      = i_flag_buffer && last_elem;
            drop        = i_flag_buffer && !last_elem;
            // A flag landing on the final MAC of the group opens the next group.
            group_start = last_elem && final_blk;
            if (last_elem && !accept) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx            <= '0;
         blk_cnt        <= 8'd0;
         blk_total      <= 8'd1;
         acc            <= '0;
         o_result       <= '0;
         o_result_valid <= 1'b0;
         o_drop         <= 1'b0;
         // NOTE: the work arrays are small register files, so they take the async reset too.
         for (int k = 0; k < N; k++) begin
            tensor_q[k] <= '0;
            weight_q[k] <= '0;
         end
      end else begin
         o_result_valid <= 1'b0;
         o_drop         <= drop;
         if (state == MAC) begin
            if (last_elem) begin
               idx <= '0;
               if (final_blk) begin
                  o_result       <= acc_next;
                  o_result_valid <= 1'b1;
                  acc            <= '0;
                  blk_cnt        <= 8'd0;
               end else begin
                  acc     <= acc_next;
                  blk_cnt <= blk_cnt + 8'd1;
               end
            end else begin
               acc <= acc_next;
               idx <= idx + IDX_W'(1);
            end
         end
         if (accept) begin
            idx <= '0;
            for (int k = 0; k < N; k++) begin
               tensor_q[k] <= i_matrix_tensor[k*DATA_WIDTH +: DATA_WIDTH];
               weight_q[k] <= i_matrix_weight[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (group_start) blk_total <= (i_blocks == 8'd0) ? 8'd1 : i_blocks;
         end
      end
   end

endmodule

// File: tb/tb_gemm_mac_unit.sv
// Directed bench for gemm_mac_unit: stimulus pushes expected sums into a queue,
// a negedge monitor pops and compares on every o_result_valid pulse.
module tb_gemm_mac_unit;

   localparam int NE = 9;
   localparam int DW = 8;
   localparam int VW = NE * DW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_flag_buffer;
   logic [VW-1:0] i_matrix_tensor;
   logic [VW-1:0] i_matrix_weight;
   logic [7:0]    i_blocks;
   logic [31:0]   o_result;
   logic          o_result_valid;
   logic          o_busy;
   logic          o_drop;

   gemm_mac_unit #(.DATA_WIDTH(DW), .S2P_SIZE(3), .ACC_WIDTH(32)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .i_flag_buffer   (i_flag_buffer),
      .i_matrix_tensor (i_matrix_tensor),
      .i_matrix_weight (i_matrix_weight),
      .i_blocks        (i_blocks),
      .o_result        (o_result),
      .o_result_valid  (o_result_valid),
      .o_busy          (o_busy),
      .o_drop          (o_drop)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          flag_cyc = 0;
   int          valid_cyc = 0;
   int          valid_cnt = 0;
   int          drop_cnt = 0;
   int          busy_gaps = 0;
   logic        track_busy = 1'b0;
   logic [31:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (o_result_valid) begin
         valid_cnt++;
         valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_result: got 0x%08h expected no valid pulse", o_result);
         end else begin
            check("result", o_result, exp_q.pop_front());
         end
      end
      if (o_drop) drop_cnt++;
      if (track_busy && !o_busy) busy_gaps++;
   end

   function automatic logic [VW-1:0] fill(input logic [7:0] v);
      logic [VW-1:0] r;
      for (int k = 0; k < NE; k++) r[k*DW +: DW] = v;
      return r;
   endfunction

   // Entered just after a posedge; returns 1 time unit after the accepting edge E0.
   task automatic pulse_flag(input logic [VW-1:0] t, input logic [VW-1:0] w, input logic [7:0] b);
      i_matrix_tensor = t;
      i_matrix_weight = w;
      i_blocks        = b;
      i_flag_buffer   = 1'b1;
      @(posedge clk);
      #1;
      flag_cyc        = cyc;
      i_flag_buffer   = 1'b0;
      i_matrix_tensor = VW'({$urandom(), $urandom(), $urandom()});
      i_matrix_weight = VW'({$urandom(), $urandom(), $urandom()});
      i_blocks        = 8'($urandom());
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && (exp_q.size() != 0 || o_busy); i++) begin
         @(posedge clk);
         #2;
      end
      @(negedge clk);
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VW-1:0] tv, wv;
      rstn = 1'b0;
      i_flag_buffer = 1'b0;
      i_matrix_tensor = '0;
      i_matrix_weight = '0;
      i_blocks = 8'd0;
      #3;
      check("rst_result", o_result, 32'd0);
      check("rst_valid", 32'(o_result_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_drop", 32'(o_drop), 32'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;

      // 1*2 over nine elements, single block; latency and pulse width.
      valid_cnt = 0;
      exp_q.push_back(32'd18);
      pulse_flag(fill(8'd1), fill(8'd2), 8'd1);
      wait_done();
      check("t1_latency", 32'(valid_cyc - flag_cyc), 32'd9);
      check("t1_pulses", 32'(valid_cnt), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("t1_hold", o_result, 32'd18);

      // Negative operand: -3*4*9 = -108.
      exp_q.push_back(32'hFFFF_FF94);
      pulse_flag(fill(8'hFD), fill(8'd4), 8'd1);
      wait_done();

      // Distinct elements: sum (k-4)*(k+1), k=0..8 = 60.
      for (int k = 0; k < NE; k++) begin
         tv[k*DW +: DW] = 8'(k - 4);
         wv[k*DW +: DW] = 8'(k + 1);
      end
      exp_q.push_back(32'd60);
      pulse_flag(tv, wv, 8'd1);
      wait_done();

      // Most negative operands: (-128)*(-128)*9 = 147456.
      exp_q.push_back(32'd147456);
      pulse_flag(fill(8'h80), fill(8'h80), 8'd1);
      wait_done();

      // Two-block group, back-to-back; second flag's i_blocks must be ignored.
      valid_cnt = 0; drop_cnt = 0; busy_gaps = 0;
      exp_q.push_back(32'd45);
      pulse_flag(fill(8'd1), fill(8'd1), 8'd2);
      track_busy = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      pulse_flag(fill(8'd2), fill(8'd2), 8'd5);
      repeat (8) @(posedge clk);
      #1;
      track_busy = 1'b0;
      wait_done();
      check("t5_pulses", 32'(valid_cnt), 32'd1);
      check("t5_drops", 32'(drop_cnt), 32'd0);
      check("t5_busy_gaps", 32'(busy_gaps), 32'd0);

      // Back-to-back single-block groups: new group starts on the final MAC edge.
      valid_cnt = 0;
      exp_q.push_back(32'd9);
      exp_q.push_back(32'd36);
      pulse_flag(fill(8'd1), fill(8'd1), 8'd1);
      repeat (8) @(posedge clk);
      #1;
      pulse_flag(fill(8'd2), fill(8'd2), 8'd1);
      wait_done();
      check("t6_pulses", 32'(valid_cnt), 32'd2);

      // Flag four cycles into MAC is dropped.
      valid_cnt = 0; drop_cnt = 0;
      exp_q.push_back(32'd9);
      pulse_flag(fill(8'd1), fill(8'd1), 8'd1);
      repeat (3) @(posedge clk);
      #1;
      pulse_flag(fill(8'd5), fill(8'd5), 8'd1);
      wait_done();
      check("t7_drops", 32'(drop_cnt), 32'd1);
      check("t7_pulses", 32'(valid_cnt), 32'd1);

      // Asynchronous reset mid-MAC discards the partial sum.
      pulse_flag(fill(8'd7), fill(8'd7), 8'd1);
      repeat (4) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("mid_rst_result", o_result, 32'd0);
      check("mid_rst_valid", 32'(o_result_valid), 32'd0);
      check("mid_rst_busy", 32'(o_busy), 32'd0);
      check("mid_rst_drop", 32'(o_drop), 32'd0);
      @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      valid_cnt = 0;
      exp_q.push_back(32'd27);
      pulse_flag(fill(8'd1), fill(8'd3), 8'd1);
      wait_done();
      check("t8_pulses", 32'(valid_cnt), 32'd1);

      // i_blocks = 0 behaves as 1.
      exp_q.push_back(32'd9);
      pulse_flag(fill(8'd1), fill(8'd1), 8'd0);
      wait_done();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
